// File: rtl/msx_tape_pkg.sv
// Shared types and helpers for the MSX cassette FSK encoder.
package msx_tape_pkg;

  typedef enum logic [2:0] {IDLE, HDR, START, DATA, STOP} tape_state_t;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 2;

  // Clocks per quarter-bit; every bit is built from four equal quarters.
  function automatic int qtr_clocks(input int clk_hz, input int baud);
    return clk_hz / (4 * baud);
  endfunction

endpackage

// File: rtl/msx_tape_bitgen.sv
// Quarter-bit timing and FSK level generation for one tape bit (owns qcnt and phase).
// The level is registered from the next-cycle state so it has no combinational path from inputs.
module msx_tape_bitgen #(
  parameter int QTR = 10
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_run,
  input  logic i_go,
  input  logic i_bit,
  input  logic i_freeze,
  output logic o_level,
  output logic o_last_clk,
  output logic o_bit_end
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

  logic [QW-1:0] r_qcnt;
  logic [QW-1:0] w_qcnt_nxt;
  logic [1:0]    r_phase;
  logic [1:0]    w_phase_nxt;
  logic          r_level;
  logic          w_level_nxt;
  logic          w_qtr_last;

  assign w_qtr_last = (r_qcnt == QW'(QTR - 1));
  assign o_last_clk = w_qtr_last && (r_phase == 2'd3);
  assign o_bit_end  = o_last_clk && i_run && !i_freeze;
  assign o_level    = r_level;

  // Counters sit at zero when idle or frozen, so a paused bit restarts cleanly.
  always_comb begin
    w_qcnt_nxt  = '0;
    w_phase_nxt = '0;
    if (i_run && !i_freeze) begin
      if (w_qtr_last) begin
        w_phase_nxt = r_phase + 2'd1;
      end else begin
        w_qcnt_nxt  = r_qcnt + QW'(1);
        w_phase_nxt = r_phase;
      end
    end
  end

  // A 1-bit is high in quarters 0 and 2, a 0-bit in quarters 0 and 1.
  always_comb begin
    w_level_nxt = 1'b0;
    if (i_go && !i_freeze) begin
      w_level_nxt = i_bit ? ~w_phase_nxt[0] : ~w_phase_nxt[1];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_qcnt  <= '0;
      r_phase <= '0;
      r_level <= 1'b0;
    end else begin
      r_qcnt  <= w_qcnt_nxt;
      r_phase <= w_phase_nxt;
      r_level <= w_level_nxt;
    end
  end

endmodule

// File: rtl/msx_tape_encoder.sv
// MSX 1200-baud cassette FSK encoder: header tone, 1+8+2 byte framing, valid/ready byte intake.
// Optional MSX_TAPE_ENC_MOTOR_EN adds a motor input that pauses the stream while low.
module msx_tape_encoder
  import msx_tape_pkg::*;
#(
  parameter int CLK_HZ         = 21477270,
  parameter int BAUD           = 1200,
  parameter int LONG_HDR_BITS  = 8000,
  parameter int SHORT_HDR_BITS = 2000
) (
  input  logic       clk_sys,
  input  logic       reset,
`ifdef MSX_TAPE_ENC_MOTOR_EN
  input  logic       motor,
`endif
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       hdr_start,
  input  logic       hdr_long,
  output logic       busy,
  output logic       byte_done,
  output logic       tape_out
);

  localparam int QTR = qtr_clocks(CLK_HZ, BAUD);
  localparam int HW  = (LONG_HDR_BITS > 1) ? $clog2(LONG_HDR_BITS) : 1;
  localparam int BW  = $clog2(DATA_BITS);

  if (QTR < 1 || SHORT_HDR_BITS < 1 || SHORT_HDR_BITS > LONG_HDR_BITS) begin : g_bad_cfg
    $error("msx_tape_encoder: QTR must be >= 1 and 1 <= SHORT_HDR_BITS <= LONG_HDR_BITS");
  end

  tape_state_t   r_state;
  tape_state_t   w_state_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic [BW-1:0] r_bitcnt;
  logic [BW-1:0] w_bitcnt_nxt;
  logic [HW-1:0] r_hdrcnt;
  logic [HW-1:0] w_hdrcnt_nxt;
  logic          r_byte_done;
  logic          w_done_nxt;
  logic          w_ready;
  logic          w_bit_nxt;
  logic          w_run;
  logic          w_go;
  logic          w_freeze;
  logic          w_level;
  logic          w_last_clk;
  logic          w_bit_end;

`ifdef MSX_TAPE_ENC_MOTOR_EN
  assign w_freeze = ~motor;
`else
  assign w_freeze = 1'b0;
`endif

  assign w_run     = (r_state != IDLE);
  assign w_go      = (w_state_nxt != IDLE);
  assign s_ready   = w_ready;
  assign busy      = w_run;
  assign byte_done = r_byte_done;
  assign tape_out  = w_level;

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_hdrcnt_nxt = r_hdrcnt;
    w_ready      = 1'b0;
    w_done_nxt   = 1'b0;
    if (!w_freeze) begin
      case (r_state)
        IDLE: begin
          w_bitcnt_nxt = '0;
          if (hdr_start) begin
            // Header counter holds bits remaining after the current one.
            w_hdrcnt_nxt = hdr_long ? HW'(LONG_HDR_BITS - 1) : HW'(SHORT_HDR_BITS - 1);
            w_state_nxt  = HDR;
          end else begin
            w_ready = 1'b1;
            if (s_valid) begin
              w_shift_nxt = s_data;
              w_state_nxt = START;
            end
          end
        end
        HDR: begin
          if (w_bit_end) begin
            if (r_hdrcnt == '0) w_state_nxt = IDLE;
            else                w_hdrcnt_nxt = r_hdrcnt - HW'(1);
          end
        end
        START: begin
          if (w_bit_end) begin
            if (r_bitcnt == BW'(START_BITS - 1)) begin
              w_bitcnt_nxt = '0;
              w_state_nxt  = DATA;
            end else begin
              w_bitcnt_nxt = r_bitcnt + BW'(1);
            end
          end
        end
        DATA: begin
          if (w_bit_end) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            if (r_bitcnt == BW'(DATA_BITS - 1)) begin
              w_bitcnt_nxt = '0;
              w_state_nxt  = STOP;
            end else begin
              w_bitcnt_nxt = r_bitcnt + BW'(1);
            end
          end
        end
        STOP: begin
          // Taking the next byte on the final clock keeps a stream gapless.
          if (r_bitcnt == BW'(STOP_BITS - 1) && w_last_clk) w_ready = 1'b1;
          if (w_bit_end) begin
            if (r_bitcnt == BW'(STOP_BITS - 1)) begin
              w_done_nxt   = 1'b1;
              w_bitcnt_nxt = '0;
              if (s_valid) begin
                w_shift_nxt = s_data;
                w_state_nxt = START;
              end else begin
                w_state_nxt = IDLE;
              end
            end else begin
              w_bitcnt_nxt = r_bitcnt + BW'(1);
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    case (w_state_nxt)
      HDR:     w_bit_nxt = 1'b1;
      START:   w_bit_nxt = 1'b0;
      DATA:    w_bit_nxt = w_shift_nxt[0];
      STOP:    w_bit_nxt = 1'b1;
      default: w_bit_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_hdrcnt    <= '0;
      r_byte_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_hdrcnt    <= w_hdrcnt_nxt;
      r_byte_done <= w_done_nxt;
    end
  end

  msx_tape_bitgen #(
    .QTR(QTR)
  ) u_bitgen (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .i_run      (w_run),
    .i_go       (w_go),
    .i_bit      (w_bit_nxt),
    .i_freeze   (w_freeze),
    .o_level    (w_level),
    .o_last_clk (w_last_clk),
    .o_bit_end  (w_bit_end)
  );

endmodule

// File: tb/tb_msx_tape_encoder.sv
// Scoreboard bench for msx_tape_encoder: the driver predicts per-bit waveforms, busy runs and
// byte_done timing from the tape format; an independent monitor compares what the DUT emits.
module tb_msx_tape_encoder;

  localparam int TCLK    = 48000;
  localparam int TBAUD   = 1200;
  localparam int TQ      = TCLK / (4 * TBAUD);
  localparam int BITLEN  = 4 * TQ;
  localparam int SHORT_N = 4;
  localparam int LONG_N  = 8;
  localparam int FRAME   = 11 * BITLEN;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       hdr_start;
  logic       hdr_long;
  logic       busy;
  logic       byte_done;
  logic       tape_out;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int model_end = 0;
  int last_acc = 0;
  bit last_is_byte = 1'b0;

  logic [BITLEN-1:0] q_wave[$];
  int                q_done[$];
  int                q_run[$];

  msx_tape_encoder #(
    .CLK_HZ(TCLK), .BAUD(TBAUD), .LONG_HDR_BITS(LONG_N), .SHORT_HDR_BITS(SHORT_N)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
`ifdef MSX_TAPE_ENC_MOTOR_EN
    .motor     (1'b1),
`endif
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .hdr_start (hdr_start),
    .hdr_long  (hdr_long),
    .busy      (busy),
    .byte_done (byte_done),
    .tape_out  (tape_out)
  );

  initial forever #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // One bit on tape: a 1 is a 2400 Hz square (quarters H,L,H,L), a 0 is one 1200 Hz cycle (H,H,L,L).
  function automatic logic [BITLEN-1:0] wave_of(input logic b);
    logic [BITLEN-1:0] w;
    for (int k = 0; k < BITLEN; k++) w[k] = b ? (((k / TQ) % 2) == 0) : (k < 2 * TQ);
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic add_run(input int a, input int len);
    if (a == model_end && q_run.size() > 0) q_run[q_run.size() - 1] = q_run[q_run.size() - 1] + len;
    else q_run.push_back(len);
  endtask

  task automatic model_byte(input logic [7:0] d);
    int a;
    a = cyc + 1;
    add_run(a, FRAME);
    q_wave.push_back(wave_of(1'b0));
    for (int i = 0; i < 8; i++) q_wave.push_back(wave_of(d[i]));
    q_wave.push_back(wave_of(1'b1));
    q_wave.push_back(wave_of(1'b1));
    q_done.push_back(a);
    model_end = a + FRAME;
    last_is_byte = 1'b1;
    last_acc = a;
  endtask

  task automatic send(input logic [7:0] d);
    bit   done;
    logic exp_rdy;
    done = 1'b0;
    s_data = d;
    s_valid = 1'b1;
    for (int n = 0; n < 3000 && !done; n++) begin
      #1;
      exp_rdy = (cyc >= model_end && !hdr_start) || (last_is_byte && cyc == model_end - 1);
      chk("s_ready", 64'(s_ready), 64'(exp_rdy));
      if (s_ready) begin
        model_byte(d);
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted (cycle %0d)", d, cyc);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    s_valid = 1'b0;
    for (int n = 0; n < 5000 && cyc < model_end; n++) tick();
  endtask

  task automatic header(input logic lng, input logic with_byte, input logic [7:0] d);
    int nb;
    int a;
    wait_idle();
    hdr_start = 1'b1;
    hdr_long = lng;
    if (with_byte) begin
      s_valid = 1'b1;
      s_data = d;
    end
    #1;
    chk("s_ready_during_hdr_start", 64'(s_ready), 64'(0));
    nb = lng ? LONG_N : SHORT_N;
    a = cyc + 1;
    add_run(a, nb * BITLEN);
    for (int i = 0; i < nb; i++) q_wave.push_back(wave_of(1'b1));
    model_end = a + nb * BITLEN;
    last_is_byte = 1'b0;
    tick();
    hdr_start = 1'b0;
    hdr_long = 1'($urandom_range(0, 1));
    if (with_byte) send(d);
  endtask

  // Monitor: assembles tape_out into bit-length chunks while busy and scores everything the DUT emits.
  initial begin
    logic [BITLEN-1:0] acc;
    int                acc_n;
    int                run_len;
    logic              prev_busy;
    acc = '0;
    acc_n = 0;
    run_len = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        acc_n = 0;
        run_len = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy) begin
          acc[acc_n] = tape_out;
          acc_n++;
          run_len++;
          if (acc_n == BITLEN) begin
            if (q_wave.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL bit_wave: unexpected bit %0h (cycle %0d)", acc, cyc);
            end else begin
              chk("bit_wave", 64'(acc), 64'(q_wave.pop_front()));
            end
            acc_n = 0;
          end
        end else if (prev_busy) begin
          chk("idle_level", 64'(tape_out), 64'(0));
          chk("partial_bit", 64'(acc_n), 64'(0));
          acc_n = 0;
          if (q_run.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL busy_run: unexpected run of %0d clocks (cycle %0d)", run_len, cyc);
          end else begin
            chk("busy_run", 64'(run_len), 64'(q_run.pop_front()));
          end
          run_len = 0;
        end
        if (byte_done) begin
          if (q_done.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL byte_done: unexpected pulse (cycle %0d)", cyc);
          end else begin
            chk("byte_done_latency", 64'(cyc - q_done.pop_front()), 64'(FRAME));
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    int nb;
    int cnt;
    reset = 1'b1;
    s_data = '0;
    s_valid = 1'b0;
    hdr_start = 1'b0;
    hdr_long = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_tape_out", 64'(tape_out), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_byte_done", 64'(byte_done), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));

    send(8'hA5);
    wait_idle();

    send(8'h00);
    send(8'hFF);
    wait_idle();

    header(1'b0, 1'b0, 8'h00);
    header(1'b1, 1'b0, 8'h00);
    header(1'b0, 1'b1, 8'h3C);
    wait_idle();

    // hdr_start while a byte is in flight must be ignored.
    send(8'h5A);
    repeat (20) tick();
    hdr_start = 1'b1;
    hdr_long = 1'b1;
    #1;
    chk("s_ready_stray_hdr", 64'(s_ready), 64'(0));
    tick();
    hdr_start = 1'b0;
    wait_idle();

    // Reset 100 clocks into a byte aborts it.
    send(8'h55);
    while (cyc < last_acc + 99) tick();
    reset = 1'b1;
    q_wave.delete();
    q_done.delete();
    q_run.delete();
    model_end = 0;
    last_is_byte = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_tape_out", 64'(tape_out), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_s_ready", 64'(s_ready), 64'(1));
    cnt = 0;
    for (int n = 0; n < FRAME + 10; n++) begin
      tick();
      if (byte_done) cnt++;
    end
    chk("abort_no_byte_done", 64'(cnt), 64'(0));

    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: send(8'($urandom));
        1: begin
          nb = $urandom_range(2, 3);
          for (int j = 0; j < nb; j++) send(8'($urandom));
        end
        2: header(1'($urandom_range(0, 1)), 1'b0, 8'h00);
        default: header(1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
      endcase
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    wait_idle();
    repeat (5) tick();
    chk("leftover_bits", 64'(q_wave.size()), 64'(0));
    chk("leftover_byte_done", 64'(q_done.size()), 64'(0));
    chk("leftover_runs", 64'(q_run.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
